// File: rtl/ms_tmr32_cpfifo.sv
// ms_tmr32_cpfifo
// Capture buffer for the 32-bit timer. Each rising edge of cp_flag pushes
// cp_count into a first-word-fall-through FIFO. The block also reports
// level, threshold and sticky-overflow status.
//
// Ports:
//   clk, rst_n     block clock, synchronous active-low reset
//   en             block enable (only cp_q keeps tracking while low)
//   clr            synchronous flush of pointers, level and ovf
//   cp_flag        capture event from the timer (level or pulse)
//   cp_count[31:0] captured count, sampled on the cp_flag rising edge
//   rd             pop request, one entry per cycle
//   rdata[31:0]    head entry, 0 when empty
//   level[AW:0]    number of stored entries
//   empty, full    level == 0 / level == DEPTH
//   thr[AW:0]      threshold; thr_flag = level >= thr && thr != 0
//   ovf            sticky, set when a capture is dropped on a full FIFO
module ms_tmr32_cpfifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          cp_flag,
    input  logic [31:0]   cp_count,
    input  logic          rd,
    output logic [31:0]   rdata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    input  logic [AW:0]   thr,
    output logic          thr_flag,
    output logic          ovf
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   mem_q [DEPTH];
    logic          cp_q, cp_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;

    logic push_req, pop_req, push_ok, mem_we;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_FULL);
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign thr_flag = (level_q >= thr) && (thr != '0);
    // Storage is never reset, so mask the head while nothing is stored.
    assign rdata    = empty ? 32'd0 : mem_q[rp_q];

    always_comb begin
        push_req = cp_flag & ~cp_q & en;
        pop_req  = rd & en & ~empty;
        // A push into a full FIFO still lands when a pop frees the head slot.
        push_ok  = push_req & (~full | pop_req);
        mem_we   = 1'b0;

        cp_d    = cp_flag;
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        ovf_d   = ovf_q;

        if (clr) begin
            // cp_q still follows cp_flag, so a coincident edge is discarded.
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (push_ok) begin
                mem_we = 1'b1;
                wp_d   = wp_q + PTR_ONE;
            end
            if (push_req && !push_ok)
                ovf_d = 1'b1;
            if (pop_req)
                rp_d = rp_q + PTR_ONE;
            if (push_ok && !pop_req)
                level_d = level_q + LVL_ONE;
            else if (pop_req && !push_ok)
                level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cp_q    <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cp_q    <= cp_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem_q[wp_q] <= cp_count;
    end

endmodule

// File: tb/tb_ms_tmr32_cpfifo.sv
// Self-checking bench for ms_tmr32_cpfifo. A queue models the FIFO contents:
// accepted captures are pushed when driven and popped/compared against
// rdata when the DUT pops them.
module tb_ms_tmr32_cpfifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, clr, cp_flag, rd;
    logic [31:0]   cp_count;
    logic [31:0]   rdata;
    logic [AW:0]   level, thr;
    logic          empty, full, thr_flag, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    bit          m_ovf = 1'b0;

    always #5 clk = ~clk;

    ms_tmr32_cpfifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .cp_flag(cp_flag), .cp_count(cp_count), .rd(rd),
        .rdata(rdata), .level(level), .empty(empty), .full(full),
        .thr(thr), .thr_flag(thr_flag), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".level"}, 32'(level), 32'(sz));
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".full"},  32'(full),  32'(sz == DEPTH));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".thr"},   32'(thr_flag), 32'((sz >= int'(thr)) && (thr != 0)));
        check({tag, ".rdata"}, rdata, (sz != 0) ? exp_q[0] : 32'd0);
    endtask

    // One capture edge (high for one cycle, then low), optionally with rd.
    task automatic capture(input logic [31:0] v, input bit do_rd);
        bit popped;
        popped   = en && do_rd && (exp_q.size() > 0);
        if (popped) check("head", rdata, exp_q[0]);
        cp_flag  = 1'b1;
        cp_count = v;
        rd       = do_rd;
        tick();
        if (en) begin
            if (popped) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(v);
            else m_ovf = 1'b1;
        end
        cp_flag  = 1'b0;
        rd       = 1'b0;
        cp_count = $urandom;
        tick();
        check_state("cap");
    endtask

    task automatic pop();
        bit popped;
        popped = en && (exp_q.size() > 0);
        if (popped) check("head", rdata, exp_q[0]);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        if (popped) void'(exp_q.pop_front());
        check_state("pop");
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        check_state("clr");
    endtask

    initial begin
        logic [31:0] cnt;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; cp_flag = 1'b0; rd = 1'b0;
        cp_count = 32'd0; thr = '0;

        // Reset state
        repeat (5) tick();
        rst_n = 1'b1;
        tick();
        check_state("reset");
        pop();
        pop();

        // FWFT order
        capture(100, 0); capture(200, 0); capture(300, 0);
        pop(); pop(); pop();
        check("fwft_empty", 32'(empty), 32'd1);

        // Level-held flag produces one push
        cp_flag = 1'b1; cp_count = 7;
        repeat (10) tick();
        exp_q.push_back(7);
        cp_flag = 1'b0;
        tick();
        check_state("held");
        pop();

        // Overflow
        for (int i = 1; i <= 9; i++) capture(i, 0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_set",  32'(ovf),  32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_seq", rdata, 32'(i));
            pop();
        end
        check("ovf_sticky", 32'(ovf), 32'd1);
        pulse_clr();

        // Simultaneous push/pop when full
        for (int i = 0; i < DEPTH; i++) capture(10 + i, 0);
        capture(99, 1);
        check("pp_full_lvl", 32'(level), 32'(DEPTH));
        check("pp_full_ovf", 32'(ovf), 32'd0);
        check("pp_full_head", rdata, 32'd11);
        while (exp_q.size() > 1) pop();
        check("pp_full_tail", rdata, 32'd99);
        pop();

        // Simultaneous push/pop when empty
        capture(55, 1);
        check("pp_empty_lvl", 32'(level), 32'd1);
        pop();

        // Threshold
        thr = 3;
        capture(1, 0); capture(2, 0);
        check("thr_below", 32'(thr_flag), 32'd0);
        capture(3, 0);
        check("thr_rise", 32'(thr_flag), 32'd1);
        pop();
        check("thr_fall", 32'(thr_flag), 32'd0);
        pop(); pop();
        thr = 0;

        // Enable: edge while disabled is dropped and not replayed
        en = 1'b0;
        capture(77, 0);
        cp_flag = 1'b1; cp_count = 78;
        tick();
        en = 1'b1;
        tick();
        cp_flag = 1'b0;
        tick();
        check_state("en_replay");

        // Edge coincident with clr is discarded
        capture(5, 0);
        cp_flag = 1'b1; cp_count = 6; clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        tick();
        cp_flag = 1'b0;
        tick();
        check_state("clr_edge");

        // Timer-like stream: increasing counts, drained after each event
        cnt = 32'd1000;
        for (int i = 0; i < 20; i++) begin
            cnt = cnt + 32'($urandom_range(1, 50));
            repeat ($urandom_range(0, 3)) tick();
            capture(cnt, 0);
            pop();
        end

        // Random mix
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 0) thr = 4'($urandom_range(0, DEPTH));
            case ($urandom_range(0, 3))
                0, 1: capture($urandom, 0);
                2:    capture($urandom, 1);
                default: pop();
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ms_tmr32_cpfifo.md
# ms_tmr32_cpfifo

Capture buffer that sits directly downstream of the 32-bit timer (ms_tmr32). It records every capture event reported on the timer's `cp_flag`/`cp_count` pair into a first-word-fall-through FIFO. Software or a bus wrapper can then drain back-to-back captures without losing samples between reads. The block also provides level, threshold and sticky-overflow status for interrupt generation.

## Interface
Parameters:
- `DEPTH`, 8, number of 32-bit entries; must be a power of two, 2..256.
- `AW`, 3, log2(`DEPTH`).

Ports:
- `clk`  in  1  block clock, same clock as the timer.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `en`  in  1  block enable; when 0, push and pop are ignored and all state holds.
- `clr`  in  1  synchronous flush; empties the FIFO and clears `ovf`.
- `cp_flag`  in  1  capture event from the timer; level or pulse.
- `cp_count`  in  32  captured count from the timer; valid while `cp_flag` is high.
- `rd`  in  1  pop request; one entry per cycle while high.
- `rdata`  out  32  head entry (FWFT); 0 when empty.
- `level`  out  AW+1  number of stored entries, 0..`DEPTH`.
- `empty`  out  1  `level` == 0.
- `full`  out  1  `level` == `DEPTH`.
- `thr`  in  AW+1  threshold level.
- `thr_flag`  out  1  (`level` >= `thr`) and (`thr` != 0).
- `ovf`  out  1  sticky; set when a capture is dropped.

## Operation
- **Edge detect.** A registered copy `cp_q` of `cp_flag` is kept. A push request occurs when `cp_flag & ~cp_q & en`. A `cp_flag` held high for N cycles produces exactly one push. `cp_count` is written as sampled in the same cycle as the rising edge.
- **Pop request.** A pop request is `rd & en & ~empty`. `rd` while empty is ignored and has no side effect.
- **Storage.** Circular buffer with write pointer `wp` and read pointer `rp`, each AW bits and wrapping modulo `DEPTH`, plus an AW+1-bit `level` counter.
- **Priority, highest first:**
  1. `rst_n`=0: `wp`=`rp`=`level`=0, `ovf`=0, `cp_q`=0.
  2. `clr`=1: `wp`=`rp`=`level`=0, `ovf`=0. `cp_q` still tracks `cp_flag`, so an edge coincident with `clr` is discarded.
  3. Push and pop in the same cycle:
     - Not full: both occur, `level` unchanged.
     - Full: both occur, no overflow, `level` stays `DEPTH`.
     - Empty: only the push occurs, because the pop request is gated by `~empty`.
  4. Push only: if not full, write `mem[wp]`, `wp`+1, `level`+1. If full, drop the sample, set `ovf`=1, and leave storage unchanged.
  5. Pop only: `rp`+1, `level`-1.
- **`ovf`.** Remains 1 until `clr` or reset. It is not cleared by reads.
- **Enable.** When `en`=0 nothing changes except `cp_q`. `cp_q` keeps updating, so an edge that occurs while disabled is not replayed when `en` returns to 1.
- **`rdata`.** Equals `mem[rp]` when `level` != 0, otherwise 0. Storage contents are not reset, only the pointers are.

## Timing
- Reset values:
  - `rdata`=0, `level`=0, `empty`=1, `full`=0, `ovf`=0, `thr_flag`=0.
  - Memory contents are don't-care but never visible, because `rdata` is masked to 0 when empty.
- **Push latency:** a `cp_flag` rising edge sampled at clock edge k produces updated `level`, `empty` and `rdata` immediately after edge k. This is one cycle after `cp_flag` rises in the registered domain.
- **Pop:** `rd` sampled high at edge k advances `rdata` to the next entry after edge k. It reads 0 if that pop emptied the FIFO.
- **Status outputs:** `empty`, `full` and `thr_flag` are derived combinationally from registered `level`. They have no extra latency and are glitch-free relative to `clk`.
- **`ovf`:** asserts on the edge that drops the sample.
- **Throughput:** one push per two cycles maximum, because a push needs a low-high transition on `cp_flag`. One pop per cycle.

## Test plan
- **Reset state.** Hold `rst_n`=0 for 5 cycles, then release with `en`=1 -> `level`=0, `empty`=1, `rdata`=0, `ovf`=0. `rd` pulses have no effect.
- **FWFT order.** Drive edges with `cp_count`=100, 200, 300, then pop 3 times -> `rdata` reads 100, 200, 300 in order, and `empty`=1 after the third pop.
- **Level-held flag.** Hold `cp_flag` high for 10 cycles with `cp_count`=7 -> `level`=1, single entry 7.
- **Overflow.** With `DEPTH`=8, push 9 captures 1..9 -> `full`=1, `ovf`=1, and the pop sequence is 1..8. `ovf` stays 1 until `clr` is pulsed, after which `level`=0 and `ovf`=0.
- **Simultaneous push/pop.**
  - When full: a capture edge with `rd`=1 gives `level`=8, `ovf`=0, the oldest entry is removed, and the new value is at the tail.
  - When empty: a capture edge with `rd`=1 gives `level`=1.
- **Threshold and enable.** With `thr`=3, `thr_flag` rises with the third push and falls on the next pop. With `en`=0, a capture edge leaves `level` unchanged, and re-enabling does not replay it.
- **Timer integration.** With a live ms_tmr32 (`clk_src`=1, `cp_en`=1, `cp_event`=1 and `ctr_in` toggling), the successive FIFO entries equal successive `cp_count` values, with no losses while the FIFO is drained each event.
